// File: rtl/tl_mon_pkg.sv
// Shared TileLink monitor definitions: opcodes, the first-beat record and the beat-count helper.
package tl_mon_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    // Record fields are sized for the widest supported size/source; narrower ones zero-extend.
    localparam int REC_FIELD_W = 8;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [REC_FIELD_W-1:0] size;
        logic [REC_FIELD_W-1:0] source;
    } beat_rec_t;

    function automatic int unsigned num_beats(input logic [2:0] opcode, input int unsigned size,
                                              input logic is_d, input int unsigned beat_log2);
        logic multi;
        multi = is_d ? (opcode == ACK_DATA) : (opcode == PUT_FULL || opcode == PUT_PARTIAL);
        if (multi && size > beat_log2) return 32'd1 << (size - beat_log2);
        return 32'd1;
    endfunction

    function automatic beat_rec_t make_rec(input logic [2:0] opcode,
                                           input logic [REC_FIELD_W-1:0] size,
                                           input logic [REC_FIELD_W-1:0] source);
        beat_rec_t r;
        r.opcode = opcode;
        r.size   = size;
        r.source = source;
        return r;
    endfunction

endpackage

// File: rtl/tl_inflight_monitor_if.sv
// A/D channel view plus monitor check outputs; the monitor only ever drives the ok_* and count.
interface tl_inflight_monitor_if #(
    parameter int SOURCE_W = 4,
    parameter int SIZE_W   = 3
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [SIZE_W-1:0]   a_size;
    logic [SOURCE_W-1:0] a_source;
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [SIZE_W-1:0]   d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                ok_a_unique;
    logic                ok_a_burst;
    logic                ok_d_known;
    logic                ok_progress;
    logic [SOURCE_W:0]   inflight_cnt;

    modport master (
        output a_valid, a_ready, a_opcode, a_size, a_source,
        output d_valid, d_ready, d_opcode, d_size, d_source,
        input  ok_a_unique, ok_a_burst, ok_d_known, ok_progress, inflight_cnt
    );

    modport slave (
        input  a_valid, a_ready, a_opcode, a_size, a_source,
        input  d_valid, d_ready, d_opcode, d_size, d_source,
        output ok_a_unique, ok_a_burst, ok_d_known, ok_progress, inflight_cnt
    );
endinterface

// File: rtl/tl_beat_counter.sv
// Per-channel burst tracker: down-counter of remaining beats plus the latched first-beat record.
module tl_beat_counter
    import tl_mon_pkg::*;
#(
    parameter int SIZE_W    = 3,
    parameter int SOURCE_W  = 4,
    parameter int BEAT_LOG2 = 3,
    parameter bit IS_D      = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fire_i,
    input  logic [2:0]          opcode_i,
    input  logic [SIZE_W-1:0]   size_i,
    input  logic [SOURCE_W-1:0] source_i,
    output logic                first_o,
    output logic                last_o,
    output beat_rec_t           rec_o
);

    // Largest size is 2^SIZE_W-1, so beats-1 always fits in 2^SIZE_W bits.
    localparam int CNT_W = 1 << SIZE_W;

    logic [CNT_W-1:0] cnt_q, cnt_d, load;
    beat_rec_t        rec_q, rec_d;

    always_comb begin
        load    = CNT_W'(num_beats(opcode_i, int'(size_i), IS_D, BEAT_LOG2) - 32'd1);
        first_o = (cnt_q == '0);
        last_o  = first_o ? (load == '0) : (cnt_q == CNT_W'(1));
        cnt_d   = cnt_q;
        rec_d   = rec_q;
        if (fire_i) begin
            if (first_o) begin
                cnt_d = load;
                rec_d = make_rec(opcode_i, REC_FIELD_W'(size_i), REC_FIELD_W'(source_i));
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            rec_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rec_q <= rec_d;
        end
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH A/D monitor: inflight source bitmap, burst consistency and D-progress checks.
// Define TL_MON_TIMEOUT_EN to build the forward-progress watchdog; otherwise ok_progress is tied high.
module tl_inflight_monitor
    import tl_mon_pkg::*;
#(
    parameter int SOURCE_W  = 4,
    parameter int SIZE_W    = 3,
    parameter int BEAT_LOG2 = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    tl_inflight_monitor_if.slave  bus
);

    localparam int NSRC = 1 << SOURCE_W;

    logic            a_fire, d_fire;
    logic            a_first, a_last, d_first, d_last;
    logic            a_set, d_clr, a_mismatch;
    beat_rec_t       a_rec, d_rec, a_cur;
    logic [NSRC-1:0] bitmap_q, bitmap_d;
    logic [SOURCE_W:0] cnt_q, cnt_d;
    logic            armed_q;

    assign a_fire = bus.a_valid & bus.a_ready;
    assign d_fire = bus.d_valid & bus.d_ready;

    tl_beat_counter #(
        .SIZE_W(SIZE_W), .SOURCE_W(SOURCE_W), .BEAT_LOG2(BEAT_LOG2), .IS_D(1'b0)
    ) u_a_cnt (
        .clk_i(clock), .rst_ni(reset_n), .fire_i(a_fire),
        .opcode_i(bus.a_opcode), .size_i(bus.a_size), .source_i(bus.a_source),
        .first_o(a_first), .last_o(a_last), .rec_o(a_rec)
    );

    tl_beat_counter #(
        .SIZE_W(SIZE_W), .SOURCE_W(SOURCE_W), .BEAT_LOG2(BEAT_LOG2), .IS_D(1'b1)
    ) u_d_cnt (
        .clk_i(clock), .rst_ni(reset_n), .fire_i(d_fire),
        .opcode_i(bus.d_opcode), .size_i(bus.d_size), .source_i(bus.d_source),
        .first_o(d_first), .last_o(d_last), .rec_o(d_rec)
    );

    // Only the A side needs its record compared; D burst shape is not checked here.
    logic unused_sig;
    assign unused_sig = ^{a_last, d_rec};

    assign a_set = a_fire & a_first;
    assign d_clr = d_fire & d_last;

    always_comb begin
        a_cur      = make_rec(bus.a_opcode, REC_FIELD_W'(bus.a_size), REC_FIELD_W'(bus.a_source));
        a_mismatch = (a_cur != a_rec);
        // Clear before set so a source retired and reissued in the same cycle stays inflight.
        bitmap_d = bitmap_q;
        if (d_clr) bitmap_d[bus.d_source] = 1'b0;
        if (a_set) bitmap_d[bus.a_source] = 1'b1;
        cnt_d = '0;
        for (int i = 0; i < NSRC; i++) cnt_d = cnt_d + (SOURCE_W+1)'(bitmap_d[i]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bitmap_q <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            cnt_q    <= cnt_d;
            armed_q  <= 1'b1;
        end
    end

    // armed_q holds every check high from reset until the first clock after release.
    assign bus.ok_a_unique = !armed_q ||
        !(a_set && bitmap_q[bus.a_source] && !(d_clr && (bus.d_source == bus.a_source)));
    assign bus.ok_a_burst  = !armed_q || !(a_fire && !a_first && a_mismatch);
    assign bus.ok_d_known  = !armed_q || !(d_fire && d_first && !bitmap_q[bus.d_source]);
    assign bus.inflight_cnt = cnt_q;

`ifdef TL_MON_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (d_fire || (bitmap_q == '0)) wd_d = '0;
        else if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wd_q <= '0;
        else          wd_q <= wd_d;
    end

    assign bus.ok_progress = !armed_q || (wd_q != WD_W'(TIMEOUT));
`else
    localparam int unused_timeout = TIMEOUT;
    assign bus.ok_progress = 1'b1;
`endif

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor: per-cycle vector table plus watchdog and reset sequences.
module tb_tl_inflight_monitor;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tl_inflight_monitor_if #(.SOURCE_W(4), .SIZE_W(3)) bus ();

    tl_inflight_monitor #(
        .SOURCE_W(4), .SIZE_W(3), .BEAT_LOG2(3), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic       av, ar;
        logic [2:0] aop, asz;
        logic [3:0] asrc;
        logic       dv, dr;
        logic [2:0] dop, dsz;
        logic [3:0] dsrc;
        logic       eu, eb, ek;
        logic [4:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic av, input logic ar, input logic [2:0] aop,
                                input logic [2:0] asz, input logic [3:0] asrc,
                                input logic dv, input logic dr, input logic [2:0] dop,
                                input logic [2:0] dsz, input logic [3:0] dsrc,
                                input logic eu, input logic eb, input logic ek,
                                input logic [4:0] ec);
        vec_t v;
        v.av = av; v.ar = ar; v.aop = aop; v.asz = asz; v.asrc = asrc;
        v.dv = dv; v.dr = dr; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc;
        v.eu = eu; v.eb = eb; v.ek = ek; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t idle(input logic [4:0] ec);
        return mk(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, ec);
    endfunction

    task automatic apply(input vec_t v);
        bus.a_valid = v.av; bus.a_ready = v.ar; bus.a_opcode = v.aop;
        bus.a_size = v.asz; bus.a_source = v.asrc;
        bus.d_valid = v.dv; bus.d_ready = v.dr; bus.d_opcode = v.dop;
        bus.d_size = v.dsz; bus.d_source = v.dsrc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eu, input logic eb, input logic ek,
                           input logic ep, input logic [4:0] ec);
        chk({tag, " ok_a_unique"}, 32'(bus.ok_a_unique), 32'(eu));
        chk({tag, " ok_a_burst"},  32'(bus.ok_a_burst),  32'(eb));
        chk({tag, " ok_d_known"},  32'(bus.ok_d_known),  32'(ek));
        chk({tag, " ok_progress"}, 32'(bus.ok_progress), 32'(ep));
        chk({tag, " inflight_cnt"}, 32'(bus.inflight_cnt), 32'(ec));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic wd_exp;

    initial begin
        // Get=4 PutFull=0 / Ack=0 AckData=1; columns: A{v,r,op,sz,src} D{v,r,op,sz,src} exp{uniq,burst,known,cnt}
        tbl.push_back(idle(5'd0));
        tbl.push_back(mk(1,1,4,3,3,   0,1,0,0,0,   1,1,1,0));   // Get src3
        tbl.push_back(idle(5'd1));
        tbl.push_back(idle(5'd1));
        tbl.push_back(idle(5'd1));
        tbl.push_back(idle(5'd1));
        tbl.push_back(mk(0,1,0,0,0,   1,1,1,3,3,   1,1,1,1));   // AckData src3 single beat
        tbl.push_back(idle(5'd0));
        tbl.push_back(mk(1,1,0,5,2,   0,1,0,0,0,   1,1,1,0));   // PutFull src2, 4 beats
        tbl.push_back(mk(1,1,0,5,2,   0,1,0,0,0,   1,1,1,1));
        tbl.push_back(mk(1,1,0,5,5,   0,1,0,0,0,   1,0,1,1));   // beat 3 wrong source
        tbl.push_back(mk(1,1,0,5,2,   0,1,0,0,0,   1,1,1,1));   // beat 4 ends burst
        tbl.push_back(mk(1,1,4,0,2,   0,1,0,0,0,   0,1,1,1));   // new first beat reuses src2
        tbl.push_back(mk(0,1,0,0,0,   1,1,0,0,2,   1,1,1,1));
        tbl.push_back(idle(5'd0));
        tbl.push_back(mk(1,1,4,0,7,   0,1,0,0,0,   1,1,1,0));   // Get src7
        tbl.push_back(mk(1,1,4,0,7,   0,1,0,0,0,   0,1,1,1));   // reuse src7
        tbl.push_back(mk(1,1,4,0,7,   1,1,0,0,7,   1,1,1,1));   // reuse with same-cycle retire
        tbl.push_back(idle(5'd1));
        tbl.push_back(mk(0,1,0,0,0,   1,1,0,0,7,   1,1,1,1));
        tbl.push_back(idle(5'd0));
        tbl.push_back(mk(0,1,0,0,0,   1,1,0,0,9,   1,1,0,0));   // Ack to empty bitmap
        tbl.push_back(idle(5'd0));
        tbl.push_back(mk(1,1,4,5,4,   0,1,0,0,0,   1,1,1,0));   // Get large size is one beat
        tbl.push_back(mk(1,1,4,5,10,  0,1,0,0,0,   1,1,1,1));
        tbl.push_back(mk(0,1,0,0,0,   1,1,1,5,4,   1,1,1,2));   // AckData src4, 4 beats
        tbl.push_back(mk(0,1,0,0,0,   1,1,1,5,9,   1,1,1,2));   // non-first beat not checked
        tbl.push_back(mk(0,1,0,0,0,   1,1,1,5,4,   1,1,1,2));
        tbl.push_back(mk(0,1,0,0,0,   1,1,1,5,4,   1,1,1,2));   // last beat clears src4
        tbl.push_back(idle(5'd1));
        tbl.push_back(mk(0,1,0,0,0,   1,0,0,0,9,   1,1,1,1));   // D valid without ready
        tbl.push_back(mk(1,0,4,0,10,  0,1,0,0,0,   1,1,1,1));   // A valid without ready
        tbl.push_back(mk(0,1,0,0,0,   1,1,0,0,10,  1,1,1,1));
        tbl.push_back(idle(5'd0));

        // Reset state with offending traffic on both channels.
        apply(mk(1,1,4,0,3, 1,1,0,0,9, 1,1,1,0));
        #12;
        chk_all("reset", 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);
        apply(idle(5'd0));
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clock);
            chk_all($sformatf("row%0d", i), tbl[i].eu, tbl[i].eb, tbl[i].ek, 1'b1, tbl[i].ec);
            tick();
        end

        // Watchdog: Get src1 then silence on D.
        apply(mk(1,1,4,0,1, 0,1,0,0,0, 1,1,1,0));
        tick();
        apply(idle(5'd0));
        repeat (15) tick();
        chk("wd 15 cycles ok_progress", 32'(bus.ok_progress), 32'd1);
        tick();
`ifdef TL_MON_TIMEOUT_EN
        wd_exp = 1'b0;
`else
        wd_exp = 1'b1;
`endif
        chk("wd 16 cycles ok_progress", 32'(bus.ok_progress), 32'(wd_exp));
        apply(mk(0,1,0,0,0, 1,1,0,0,1, 1,1,1,1));
        tick();
        apply(idle(5'd0));
        chk("wd after d_fire ok_progress", 32'(bus.ok_progress), 32'd1);
        chk("wd after d_fire inflight_cnt", 32'(bus.inflight_cnt), 32'd0);

        // Reset asserted in the middle of an 8-beat PutFull on src6.
        apply(mk(1,1,0,6,6, 0,1,0,0,0, 1,1,1,0));
        repeat (3) tick();
        apply(mk(1,1,0,6,5, 1,1,0,0,9, 1,1,1,1));
        #1;
        chk("midburst ok_a_burst", 32'(bus.ok_a_burst), 32'd0);
        chk("midburst inflight_cnt", 32'(bus.inflight_cnt), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_all("in reset", 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);
        apply(idle(5'd0));
        tick();
        reset_n = 1'b1;
        tick();
        apply(mk(1,1,0,6,6, 0,1,0,0,0, 1,1,1,0));
        @(negedge clock);
        chk_all("after reset", 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);
        tick();
        apply(idle(5'd0));
        chk("after reset inflight_cnt", 32'(bus.inflight_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_inflight_monitor.md
Name: tl_inflight_monitor

Overview:
- Passive TileLink-UL/UH A/D channel monitor that tracks outstanding source IDs, burst beats and forward progress.
- Emits per-cycle "legal" flags; each flag feeds a downstream assertion checker that fires when no qualifying term is high.
- Never drives the bus. Instanced beside every master port in the eval testbench.

Parameters:
- SOURCE_W, 4, width of a_source/d_source; 2^SOURCE_W inflight slots.
- SIZE_W, 3, width of a_size/d_size (log2 bytes).
- BEAT_LOG2, 3, log2 of data bus bytes per beat.
- TIMEOUT, 1024, cycles without D progress while anything is inflight before ok_progress drops.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- a_valid  in  1  A channel valid.
- a_ready  in  1  A channel ready.
- a_opcode  in  3  A opcode.
- a_size  in  SIZE_W  A size.
- a_source  in  SOURCE_W  A source ID.
- d_valid  in  1  D channel valid.
- d_ready  in  1  D channel ready.
- d_opcode  in  3  D opcode.
- d_size  in  SIZE_W  D size.
- d_source  in  SOURCE_W  D source ID.
- ok_a_unique  out  1  A first beat does not reuse an inflight source.
- ok_a_burst  out  1  A non-first beat matches the opcode, size and source of its first beat.
- ok_d_known  out  1  D first beat targets an inflight source.
- ok_progress  out  1  watchdog not expired.
- inflight_cnt  out  SOURCE_W+1  population count of the inflight bitmap.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Fire conditions: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.

Beat counting:
- Beats = 2^(size-BEAT_LOG2) when size > BEAT_LOG2, else 1.
- Multi-beat only for A PutFull (0) and PutPartial (1), and for D AccessAckData (1). All other opcodes are 1 beat.
- Each channel has a down-counter, 0 meaning idle.
- First beat: counter == 0. On the first beat, load beats-1 and latch opcode/size/source.
- Later beats: each fire decrements the counter. The last beat is the fire where the loaded or current value is 0.

Inflight bitmap (2^SOURCE_W bits):
- Set bit[a_source] on the A first-beat fire.
- Clear bit[d_source] on the D last-beat fire.
- Same-cycle update order: clear first, then set. Same source on both sides leaves the bit set.

Check outputs:
- All ok_* are combinational from current inputs and registered state. Each is 1 whenever its qualifying fire is absent.
- ok_a_unique = !(a_fire & first & bit[a_source] & !(d clear of the same source this cycle)).
- ok_a_burst = !(a_fire & !first & mismatch vs latched fields).
- ok_d_known = !(d_fire & first_d & !bit[d_source]).

Watchdog:
- Counter resets to 0 on any d_fire or when the bitmap is empty; otherwise increments, saturating at TIMEOUT.
- ok_progress = (count != TIMEOUT).

Reset:
- Bitmap, counters and latches go to 0. inflight_cnt = 0 and all ok_* = 1 while reset_n = 0.
- Assertion mid-burst abandons all state immediately.
- No check evaluates until the first clock after deassertion.

inflight_cnt is registered and updates the cycle after the fire.

Optional Feature:
- Macro: TL_MON_TIMEOUT_EN.
- Defined: the watchdog counter (width $clog2(TIMEOUT+1)) is instantiated and ok_progress behaves as above.
- Undefined: no watchdog register; ok_progress tied to 1; the TIMEOUT parameter is ignored.

Decomposition:
- Package tl_mon_pkg holds:
  - opcode localparams (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1);
  - the function num_beats(opcode, size, is_d, beat_log2);
  - a typedef for the latched first-beat record.
- Sub-module tl_beat_counter, instanced once for A and once for D. It outputs first/last and the latched record.

Test Plan:
- Get src=3 size=3, then AccessAckData src=3 5 cycles later -> bit3 set then cleared; inflight_cnt 1 then 0; all ok_* stay 1.
- PutFull src=2 size=5 (4 beats), third beat with a_source=5 -> ok_a_burst = 0 on that cycle only; the burst still ends after beat 4.
- Two A first beats on src=7 with no D between -> ok_a_unique = 0 on the second fire. Repeat with the D last beat of src=7 in the same cycle -> ok_a_unique = 1 and bit7 stays set.
- D AccessAck src=9 with empty bitmap -> ok_d_known = 0 for one cycle.
- With TL_MON_TIMEOUT_EN and TIMEOUT=16: Get src=1, no D for 16 cycles -> ok_progress = 0 on cycle 16; a d_fire returns it to 1 the next cycle. Without the macro -> ok_progress stays 1.
- Assert reset_n mid 8-beat PutFull -> inflight_cnt = 0 and ok_* = 1 immediately. After release, a new first beat on the same source -> ok_a_unique = 1.
